// File: rtl/sub_top_nios2_qsys_0_nios2_oci_dtrace_pack.sv
// Nios II OCI data-trace packer: packs 2-bit atoms into a 15-atom buffer and emits 36-bit trace words.
// Optional DTRACE_DROP_CNT_EN: never back-pressure; discard overflow atoms and count them in drop_count.
module sub_top_nios2_qsys_0_nios2_oci_dtrace_pack (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        atom_valid,
    input  logic [1:0]  atom,
    output logic        atom_ready,
    input  logic        flush,
    output logic [29:0] dct_buffer,
    output logic [3:0]  dct_count,
    output logic        tw_valid,
    input  logic        tw_ready,
    output logic [35:0] tw_data,
    output logic [7:0]  drop_count
);

    localparam int unsigned ATOM_W = 2;
    localparam int unsigned ATOMS  = 15;
    localparam int unsigned BUF_W  = ATOM_W * ATOMS;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned TYPE_W = 2;
    localparam int unsigned DROP_W = 8;

    localparam logic [TYPE_W-1:0] TYPE_FULL  = 2'b01;
    localparam logic [TYPE_W-1:0] TYPE_FLUSH = 2'b10;

    typedef struct packed {
        logic [TYPE_W-1:0] kind;
        logic [CNT_W-1:0]  count;
        logic [BUF_W-1:0]  buffer;
    } tw_word_t;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_HELD  = 1'b1
    } out_state_t;

    out_state_t        out_state_q, out_state_d;
    logic [BUF_W-1:0]  buf_q, buf_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              flush_pend_q, flush_pend_d;
    tw_word_t          tw_q, tw_d;

    logic out_free;
    logic buf_full;
    logic accept;
    logic emit;

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_state_q  <= OUT_EMPTY;
            buf_q        <= '0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            tw_q         <= '0;
        end else begin
            out_state_q  <= out_state_d;
            buf_q        <= buf_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
            tw_q         <= tw_d;
        end
    end

    // Next-state: buffer fill, emit into the output register, flush bookkeeping
    always_comb begin
        out_state_d  = out_state_q;
        buf_d        = buf_q;
        cnt_d        = cnt_q;
        flush_pend_d = flush_pend_q;
        tw_d         = tw_q;

        out_free = (out_state_q == OUT_EMPTY) || tw_ready;
        buf_full = (cnt_q == CNT_W'(ATOMS));
        accept   = atom_valid && (!buf_full || out_free);
        emit     = out_free && (buf_full || (flush_pend_q && (cnt_q != '0)));

        if (emit) begin
            tw_d.kind   = buf_full ? TYPE_FULL : TYPE_FLUSH;
            tw_d.count  = cnt_q;
            tw_d.buffer = buf_q;
            out_state_d = OUT_HELD;
            if (accept) begin
                buf_d = BUF_W'(atom);
                cnt_d = CNT_W'(1);
            end else begin
                buf_d = '0;
                cnt_d = '0;
            end
        end else begin
            if (accept) begin
                buf_d = {buf_q[BUF_W-ATOM_W-1:0], atom};
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (tw_ready) begin
                out_state_d = OUT_EMPTY;
            end
        end

        // A flush in the emitting cycle covers atoms accepted alongside it
        if (flush) begin
            flush_pend_d = 1'b1;
        end else if (emit) begin
            flush_pend_d = 1'b0;
        end else if ((cnt_q == '0) && !accept) begin
            flush_pend_d = 1'b0;
        end
    end

`ifdef DTRACE_DROP_CNT_EN
    logic [DROP_W-1:0] drop_q;

    // Saturating count of atoms refused while the buffer is full and stalled
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_q <= '0;
        end else if (atom_valid && !accept && (drop_q != {DROP_W{1'b1}})) begin
            drop_q <= drop_q + DROP_W'(1);
        end
    end

    assign atom_ready = 1'b1;
    assign drop_count = drop_q;
`else
    assign atom_ready = !buf_full || out_free;
    assign drop_count = DROP_W'(0);
`endif

    assign dct_buffer = buf_q;
    assign dct_count  = cnt_q;
    assign tw_valid   = (out_state_q == OUT_HELD);
    assign tw_data    = tw_q;

endmodule

// File: tb/tb_sub_top_nios2_qsys_0_nios2_oci_dtrace_pack.sv
// Directed self-checking bench for the data-trace packer (stream, flush, stall, reset cases).
module tb_sub_top_nios2_qsys_0_nios2_oci_dtrace_pack;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        atom_valid;
    logic [1:0]  atom;
    logic        atom_ready;
    logic        flush;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        tw_valid;
    logic        tw_ready;
    logic [35:0] tw_data;
    logic [7:0]  drop_count;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [35:0] W_FULL_A  = {2'b01, 4'hF, 30'h06C6C6C6};
    localparam logic [35:0] W_FULL_B  = {2'b01, 4'hF, 30'h31B1B1B1};
    localparam logic [35:0] W_FLUSH_3 = {2'b10, 4'h3, 30'h00000039};
    localparam logic [35:0] W_FLUSH_1 = {2'b10, 4'h1, 30'h00000002};

`ifdef DTRACE_DROP_CNT_EN
    localparam int          STALL_CYC  = 300;
    localparam logic [7:0]  EXP_DROP   = 8'd255;
    localparam logic        EXP_RDY_ST = 1'b1;
`else
    localparam int          STALL_CYC  = 3;
    localparam logic [7:0]  EXP_DROP   = 8'd0;
    localparam logic        EXP_RDY_ST = 1'b0;
`endif

    sub_top_nios2_qsys_0_nios2_oci_dtrace_pack dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .atom_valid (atom_valid),
        .atom       (atom),
        .atom_ready (atom_ready),
        .flush      (flush),
        .dct_buffer (dct_buffer),
        .dct_count  (dct_count),
        .tw_valid   (tw_valid),
        .tw_ready   (tw_ready),
        .tw_data    (tw_data),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic rdy_all;

    initial begin
        reset_n    = 1'b0;
        atom_valid = 1'b0;
        atom       = 2'd0;
        flush      = 1'b0;
        tw_ready   = 1'b1;
        #12;
        check("rst_buffer", 64'(dct_buffer), 64'd0);
        check("rst_count",  64'(dct_count),  64'd0);
        check("rst_valid",  64'(tw_valid),   64'd0);
        check("rst_data",   64'(tw_data),    64'd0);
        check("rst_drop",   64'(drop_count), 64'd0);
        check("rst_ready",  64'(atom_ready), 64'd1);
        reset_n = 1'b1;
        tick();

        // 15 atoms 0,1,2,3,... back to back -> one FULL word
        rdy_all = 1'b1;
        for (int i = 0; i < 15; i++) begin
            atom_valid = 1'b1;
            atom       = 2'(i % 4);
            #1;
            rdy_all &= atom_ready;
            tick();
        end
        atom_valid = 1'b0;
        check("full_cnt15",   64'(dct_count), 64'd15);
        check("full_nvalid",  64'(tw_valid),  64'd0);
        tick();
        check("full_valid",   64'(tw_valid),  64'd1);
        check("full_data",    64'(tw_data),   64'(W_FULL_A));
        check("full_cnt0",    64'(dct_count), 64'd0);
        check("full_ready",   64'(rdy_all),   64'd1);
        tick();
        check("full_drain",   64'(tw_valid),  64'd0);

        // 3,2,1 then flush -> FLUSH word one cycle after the flush edge
        for (int i = 0; i < 3; i++) begin
            atom_valid = 1'b1;
            atom       = 2'(3 - i);
            tick();
        end
        atom_valid = 1'b0;
        flush      = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_cnt3",   64'(dct_count), 64'd3);
        check("fl_nvalid", 64'(tw_valid),  64'd0);
        tick();
        check("fl_valid",  64'(tw_valid),  64'd1);
        check("fl_data",   64'(tw_data),   64'(W_FLUSH_3));
        check("fl_cnt0",   64'(dct_count), 64'd0);
        tick();

        // flush on an empty buffer emits nothing and does not linger
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fl0_nvalid", 64'(tw_valid), 64'd0);
        end
        atom_valid = 1'b1;
        atom       = 2'd2;
        tick();
        atom_valid = 1'b0;
        tick();
        tick();
        check("fl0_nword", 64'(tw_valid),  64'd0);
        check("fl0_cnt1",  64'(dct_count), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        check("fl1_data",  64'(tw_data),   64'(W_FLUSH_1));
        tick();

        // stall downstream: 30 atoms fill two buffers, atom 31 back-pressured
        tw_ready = 1'b0;
        rdy_all  = 1'b1;
        for (int i = 0; i < 30; i++) begin
            atom_valid = 1'b1;
            atom       = 2'(i % 4);
            #1;
            rdy_all &= atom_ready;
            tick();
        end
        check("st_ready30", 64'(rdy_all),   64'd1);
        check("st_held",    64'(tw_data),   64'(W_FULL_A));
        check("st_cnt15",   64'(dct_count), 64'd15);
        check("st_buf2",    64'(dct_buffer), 64'h31B1B1B1);
        atom       = 2'd2;
        #1;
        check("st_ready31", 64'(atom_ready), 64'(EXP_RDY_ST));
        for (int i = 0; i < STALL_CYC; i++) tick();
        check("st_hold_v",  64'(tw_valid),  64'd1);
        check("st_hold_d",  64'(tw_data),   64'(W_FULL_A));
        check("st_hold_c",  64'(dct_count), 64'd15);
        check("st_hold_b",  64'(dct_buffer), 64'h31B1B1B1);
        check("st_drop",    64'(drop_count), 64'(EXP_DROP));
        tw_ready = 1'b1;
        #1;
        check("st_release_rdy", 64'(atom_ready), 64'd1);
        tick();
        atom_valid = 1'b0;
        check("st_word2",   64'(tw_data),   64'(W_FULL_B));
        check("st_valid2",  64'(tw_valid),  64'd1);
        check("st_fresh_c", 64'(dct_count), 64'd1);
        check("st_fresh_b", 64'(dct_buffer), 64'd2);
        tick();
        check("st_drain",   64'(tw_valid),  64'd0);

        // reset while a word is held and 7 atoms are buffered
        tw_ready = 1'b0;
        flush    = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 7; i++) begin
            atom_valid = 1'b1;
            atom       = 2'd1;
            tick();
        end
        atom_valid = 1'b0;
        check("pre_rst_v", 64'(tw_valid),  64'd1);
        check("pre_rst_c", 64'(dct_count), 64'd7);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_valid", 64'(tw_valid),   64'd0);
        check("arst_data",  64'(tw_data),    64'd0);
        check("arst_count", 64'(dct_count),  64'd0);
        check("arst_buf",   64'(dct_buffer), 64'd0);
        check("arst_drop",  64'(drop_count), 64'd0);
        tick();
        reset_n = 1'b1;
        tick();
        check("post_rst_ready", 64'(atom_ready), 64'd1);
        check("post_rst_valid", 64'(tw_valid),   64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
